sdcard_spi_responder: RTL and testbench

SPI-mode-0 target (responder) that answers an SPI master on an SD-card-style 4-wire bus: SS_n, SCLK, MOSI, MISO. It is the far end of the `sdcard_*` SPI master conduit in the DE0 demo system. It is used to emulate a card, either on a second board through GPIO or in system simulation. It oversamples the bus on the system clock, delivers received bytes as single-cycle pulses, and shifts out bytes supplied through a one-deep valid/ready holding register.

---
 rtl/sdcard_spi_pkg.sv | 13 +
 rtl/sdcard_spi_responder_sync_edge_det.sv | 32 +++
 rtl/sdcard_spi_responder.sv | 144 ++++++++++++++
 tb/tb_sdcard_spi_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_spi_pkg.sv
// Shared types and constants for the SD-card SPI responder.
package sdcard_spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;

  localparam int         SPI_BITS_PER_BYTE = 8;
  localparam int         SPI_CNT_W         = $clog2(SPI_BITS_PER_BYTE);
  localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/sdcard_spi_responder_sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous input with one extra
// register that turns level changes into single-cycle rise/fall strobes.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign dout = chain[STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/sdcard_spi_responder.sv
// SPI mode-0 responder emulating an SD card: oversampled bus, byte-wide
// receive pulses and a one-deep valid/ready transmit holding register.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | not selected; MISO driven high, pad disabled, edges ignored
//   ST_ACTIVE | selected; shifting on SCLK edges, MISO = tx_shift[7]
module sdcard_spi_responder
  import sdcard_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = DEFAULT_FILL_BYTE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_ss_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       frame_active,
  output logic       tx_underrun
);

  logic                 ss_sync, ss_rise, ss_fall;
  logic                 sclk_level_unused, sclk_rise, sclk_fall;
  logic                 mosi_sync;
  logic [1:0]           mosi_edge_unused;

  spi_state_t           state, state_nxt;
  logic [SPI_CNT_W-1:0] bit_cnt;
  logic [6:0]           rx_shift;
  logic [7:0]           tx_shift;
  logic [7:0]           hold_data;
  logic                 hold_full;

  logic                 frame_start, frame_end, active_edge;
  logic                 last_bit, byte_load, tx_accept;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_ss_n),
    .dout    (ss_sync),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_sclk),
    .dout    (sclk_level_unused),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (spi_mosi),
    .dout    (mosi_sync),
    .rise    (mosi_edge_unused[0]),
    .fall    (mosi_edge_unused[1])
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ss_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (ss_rise) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // An SCLK edge coinciding with deselect belongs to the aborted frame.
  assign frame_start = (state == ST_IDLE) && ss_fall;
  assign frame_end   = (state == ST_ACTIVE) && ss_rise;
  assign active_edge = (state == ST_ACTIVE) && !ss_rise;
  assign last_bit    = (bit_cnt == SPI_CNT_W'(SPI_BITS_PER_BYTE - 1));
  assign byte_load   = frame_start ||
                       (active_edge && sclk_fall && (bit_cnt == '0));
  assign tx_accept   = tx_valid && !hold_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_shift    <= 8'hFF;
      tx_underrun <= 1'b0;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (frame_start) begin
        bit_cnt <= '0;
      end else if (frame_end) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (active_edge && sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_sync};
        bit_cnt  <= bit_cnt + 1'b1;
        if (last_bit) begin
          rx_data  <= {rx_shift, mosi_sync};
          rx_valid <= 1'b1;
        end
      end

      if (byte_load) begin
        if (hold_full) begin
          tx_shift <= hold_data;
        end else begin
          tx_shift    <= FILL_BYTE;
          tx_underrun <= 1'b1;
        end
      end else if (active_edge && sclk_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b1};
      end

      if (tx_accept) hold_data <= tx_data;
      hold_full <= (hold_full && !byte_load) || tx_accept;
    end
  end

  assign spi_miso     = (state == ST_ACTIVE) ? tx_shift[7] : 1'b1;
  assign spi_miso_oe  = (state == ST_ACTIVE);
  assign tx_ready     = !hold_full;
  assign frame_active = !ss_sync;

endmodule

// File: tb/tb_sdcard_spi_responder.sv
// Scoreboard bench for sdcard_spi_responder: a behavioural SPI master at
// 5 MHz plus a byte supplier; expected MISO and RX bytes are queued up front.
`timescale 1ns/1ps
module tb_sdcard_spi_responder;

  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b1;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, frame_active, tx_underrun;

  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt   = 0;
  int under_cnt = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];

  always #10 clk = ~clk;

  sdcard_spi_responder #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .spi_ss_n     (spi_ss_n),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .frame_active (frame_active),
    .tx_underrun  (tx_underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] pop_exp(inout logic [7:0] q[$]);
    if (q.size() == 0) return 16'hBAD0;
    return {8'h00, q.pop_front()};
  endfunction

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      check_eq("rx_data", {24'h0, rx_data}, {16'h0, pop_exp(exp_rx)});
    end
    if (tx_underrun) under_cnt++;
  end

  // Offer one byte through the holding register, waiting a bounded time for room.
  task automatic offer(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check_eq("tx_ready_timeout", {31'h0, tx_ready}, 32'h1);
    tx_data  = b;
    tx_valid = 1'b1;
    exp_miso.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 bit loop; with last set, SS_n rises together with the final SCLK fall.
  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit last,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = mo[7-b];
      #(HALF);
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
      if (last && b == nbits - 1) spi_ss_n = 1'b1;
    end
  endtask

  task automatic spi_frame(input logic [7:0] mq[$], output logic rdy_at_start);
    logic [7:0] mi;
    spi_ss_n = 1'b0;
    #(HALF);
    rdy_at_start = tx_ready;
    check_eq("oe_in_frame", {31'h0, spi_miso_oe}, 32'h1);
    check_eq("frame_active", {31'h0, frame_active}, 32'h1);
    for (int i = 0; i < mq.size(); i++) begin
      exp_rx.push_back(mq[i]);
      spi_xfer(mq[i], 8, (i == mq.size() - 1), mi);
      check_eq("miso_byte", {24'h0, mi}, {16'h0, pop_exp(exp_miso)});
    end
    #(2 * HALF);
    check_eq("rx_q_drained", exp_rx.size(), 32'h0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rdy;
    logic [7:0] mi;
    int         rx0, un0;
    logic [7:0] mq[$];

    // reset values
    repeat (3) @(negedge clk);
    check_eq("rst_miso", {31'h0, spi_miso}, 32'h1);
    check_eq("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
    check_eq("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check_eq("rst_underrun", {31'h0, tx_underrun}, 32'h0);
    check_eq("rst_frame_active", {31'h0, frame_active}, 32'h0);
    check_eq("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check_eq("rst_rx_data", {24'h0, rx_data}, 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // single byte
    un0 = under_cnt; rx0 = rx_cnt;
    offer(8'hA5);
    check_eq("held_not_ready", {31'h0, tx_ready}, 32'h0);
    mq = '{8'h3C};
    spi_frame(mq, rdy);
    check_eq("ready_at_frame_start", {31'h0, rdy}, 32'h1);
    check_eq("single_rx_pulses", rx_cnt - rx0, 32'd1);
    check_eq("single_no_underrun", under_cnt - un0, 32'd0);
    check_eq("idle_miso_high", {31'h0, spi_miso}, 32'h1);

    // underrun
    un0 = under_cnt; rx0 = rx_cnt;
    exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'hFF);
    mq = '{8'h40, 8'h00};
    spi_frame(mq, rdy);
    check_eq("underrun_pulses", under_cnt - un0, 32'd2);
    check_eq("underrun_rx_pulses", rx_cnt - rx0, 32'd2);

    // back-to-back streaming, byte N+1 offered as soon as there is room
    un0 = under_cnt; rx0 = rx_cnt;
    offer(8'h00);
    mq.delete();
    for (int i = 0; i < 16; i++) mq.push_back(8'(i) ^ 8'hF0);
    fork
      spi_frame(mq, rdy);
      for (int i = 1; i < 16; i++) offer(8'(i));
    join
    check_eq("stream_no_underrun", under_cnt - un0, 32'd0);
    check_eq("stream_rx_pulses", rx_cnt - rx0, 32'd16);
    check_eq("stream_miso_q", exp_miso.size(), 32'h0);

    // abort after 5 bits with a byte held
    un0 = under_cnt; rx0 = rx_cnt;
    offer(8'h11);
    spi_ss_n = 1'b0;
    #(HALF);
    offer(8'h99);
    spi_xfer(8'hFF, 5, 1'b1, mi);
    check_eq("abort_miso_bits", {27'h0, mi[4:0]}, {16'h0, pop_exp(exp_miso) >> 3});
    #(4 * HALF);
    check_eq("abort_no_rx", rx_cnt - rx0, 32'd0);
    check_eq("abort_hold_kept", {31'h0, tx_ready}, 32'h0);
    check_eq("abort_oe_off", {31'h0, spi_miso_oe}, 32'h0);
    mq = '{8'h22};
    spi_frame(mq, rdy);
    check_eq("abort_next_rx", rx_cnt - rx0, 32'd1);
    check_eq("abort_underrun", under_cnt - un0, 32'd0);

    // SCLK noise while deselected
    rx0 = rx_cnt;
    offer(8'hC3);
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'($urandom);
      #(HALF);
      spi_sclk = 1'b1;
      #(HALF);
      check_eq("noise_oe", {31'h0, spi_miso_oe}, 32'h0);
      spi_sclk = 1'b0;
    end
    #(2 * HALF);
    check_eq("noise_no_rx", rx_cnt - rx0, 32'd0);
    check_eq("noise_hold_kept", {31'h0, tx_ready}, 32'h0);
    mq = '{8'h5E};
    spi_frame(mq, rdy);

    // reset mid-frame with a byte held
    offer(8'hA1);
    spi_ss_n = 1'b0;
    #(HALF);
    offer(8'hB2);
    spi_xfer(8'h0F, 3, 1'b0, mi);
    #5;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_miso", {31'h0, spi_miso}, 32'h1);
    check_eq("mid_rst_oe", {31'h0, spi_miso_oe}, 32'h0);
    check_eq("mid_rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    check_eq("mid_rst_frame_active", {31'h0, frame_active}, 32'h0);
    check_eq("mid_rst_rx_data", {24'h0, rx_data}, 32'h0);
    exp_miso.delete();
    spi_ss_n = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_rst_oe", {31'h0, spi_miso_oe}, 32'h0);

    un0 = under_cnt; rx0 = rx_cnt;
    offer(8'h6D);
    mq = '{8'h81};
    spi_frame(mq, rdy);
    check_eq("post_rst_rx", rx_cnt - rx0, 32'd1);
    check_eq("post_rst_underrun", under_cnt - un0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
